// File: rtl/flag_ctrl.sv
// Flag register write arbiter: round-robin between ALU and restore path, capture/commit pipeline, branch flag test.
// Optional FLAG_CTRL_FWD_EN forwards the committing flags to the branch unit during COMMIT.
module flag_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_req,
   input  logic [3:0] alu_flags,
   output logic       alu_gnt,
   input  logic       rs_req,
   input  logic [3:0] rs_flags,
   output logic       rs_gnt,
   input  logic [3:0] fr_q,
   output logic       fr_en,
   output logic [3:0] fr_flags,
   input  logic       br_req,
   input  logic [1:0] br_sel,
   output logic       br_ready,
   output logic       br_taken,
   output logic [7:0] upd_cnt
);

`ifdef FLAG_CTRL_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      CAPT,
      COMMIT
   } state_t;

   state_t     state;
   state_t     state_next;
   logic       prio_alu;
   logic [3:0] pending;
   logic       grant_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // prio_alu set means the restore path won last, so the ALU wins a tie
   always_comb begin
      state_next = state;
      alu_gnt    = 1'b0;
      rs_gnt     = 1'b0;
      grant_ok   = rst && ((state == IDLE) || (state == COMMIT));
      if (grant_ok) begin
         if (alu_req && (prio_alu || !rs_req)) begin
            alu_gnt = 1'b1;
         end else if (rs_req) begin
            rs_gnt = 1'b1;
         end
      end
      case (state)
         IDLE:    if (alu_gnt || rs_gnt) state_next = CAPT;
         CAPT:    state_next = COMMIT;
         COMMIT:  state_next = (alu_gnt || rs_gnt) ? CAPT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_alu <= 1'b1;
         pending  <= 4'b0000;
         fr_en    <= 1'b0;
         fr_flags <= 4'b0000;
         upd_cnt  <= 8'd0;
      end else begin
         if (alu_gnt) begin
            pending  <= alu_flags;
            prio_alu <= 1'b0;
         end else if (rs_gnt) begin
            pending  <= rs_flags;
            prio_alu <= 1'b1;
         end
         fr_en <= (state == CAPT);
         if (state == CAPT) begin
            fr_flags <= pending;
            if (upd_cnt != 8'hFF) begin
               upd_cnt <= upd_cnt + 8'd1;
            end
         end
      end
   end

   // fr_q is stale until the commit lands, so branches stall unless forwarding is built in
   always_comb begin
      br_ready = 1'b0;
      br_taken = 1'b0;
      if (rst) begin
         if (state == IDLE) begin
            br_ready = br_req;
            br_taken = br_req & fr_q[br_sel];
         end else if (FWD_EN && (state == COMMIT)) begin
            br_ready = br_req;
            br_taken = br_req & fr_flags[br_sel];
         end
      end
   end

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: stimulus queues expected commits and branch results, a negedge monitor checks them.
module tb_flag_ctrl;

`ifdef FLAG_CTRL_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alu_req = 1'b0;
   logic [3:0] alu_flags = 4'b0000;
   logic       rs_req = 1'b0;
   logic [3:0] rs_flags = 4'b0000;
   logic       br_req = 1'b0;
   logic [1:0] br_sel = 2'd0;
   logic [3:0] fr_q;
   logic       alu_gnt;
   logic       rs_gnt;
   logic       fr_en;
   logic [3:0] fr_flags;
   logic       br_ready;
   logic       br_taken;
   logic [7:0] upd_cnt;

   typedef struct packed {
      logic [3:0] flags;
      logic [7:0] cnt;
   } commit_t;

   commit_t commit_q[$];
   logic    br_q[$];
   int      checks = 0;
   int      failures = 0;

   flag_ctrl dut (
      .clk(clk), .rst(rst),
      .alu_req(alu_req), .alu_flags(alu_flags), .alu_gnt(alu_gnt),
      .rs_req(rs_req), .rs_flags(rs_flags), .rs_gnt(rs_gnt),
      .fr_q(fr_q), .fr_en(fr_en), .fr_flags(fr_flags),
      .br_req(br_req), .br_sel(br_sel), .br_ready(br_ready), .br_taken(br_taken),
      .upd_cnt(upd_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural flag register fed by the DUT's write port
   always @(posedge clk or negedge rst) begin
      if (!rst) fr_q <= 4'b0000;
      else if (fr_en) fr_q <= fr_flags;
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic a_req, input logic [3:0] a_flags, input logic r_req,
                                input logic [3:0] r_flags, input logic b_req, input logic [1:0] b_sel);
      alu_req   = a_req;
      alu_flags = a_flags;
      rs_req    = r_req;
      rs_flags  = r_flags;
      br_req    = b_req;
      br_sel    = b_sel;
   endtask

   always @(negedge clk) begin : monitor
      commit_t e;
      logic    b;
      if (fr_en) begin
         if (commit_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_commit: got fr_flags %0h, expected no fr_en", fr_flags);
         end else begin
            e = commit_q.pop_front();
            checkOutput("commit_flags", {4'b0000, fr_flags}, {4'b0000, e.flags});
            checkOutput("commit_cnt", upd_cnt, e.cnt);
         end
      end
      if (br_ready) begin
         if (br_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_br_ready: got br_taken %0b, expected no br_ready", br_taken);
         end else begin
            b = br_q.pop_front();
            checkOutput("br_taken", {7'd0, br_taken}, {7'd0, b});
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      logic [7:0] cnt_exp;

      // Reset: requests and branch must be ignored while rst is low
      tick;
      applyStimulus(1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 2'd0);
      @(negedge clk);
      checkOutput("rst_alu_gnt", {7'd0, alu_gnt}, 8'd0);
      checkOutput("rst_rs_gnt", {7'd0, rs_gnt}, 8'd0);
      checkOutput("rst_br_ready", {7'd0, br_ready}, 8'd0);
      checkOutput("rst_fr_en", {7'd0, fr_en}, 8'd0);
      checkOutput("rst_fr_flags", {4'd0, fr_flags}, 8'd0);
      checkOutput("rst_upd_cnt", upd_cnt, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      rst = 1'b1;
      tick;

      // Single ALU update, then branch on Z across CAPT/COMMIT/IDLE
      applyStimulus(1'b1, 4'b0100, 1'b0, 4'h0, 1'b0, 2'd0);
      commit_q.push_back({4'b0100, 8'd1});
      @(negedge clk);
      checkOutput("single_alu_gnt", {7'd0, alu_gnt}, 8'd1);
      checkOutput("single_rs_gnt", {7'd0, rs_gnt}, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd2);
      if (FWD) br_q.push_back(1'b1);
      @(negedge clk);
      checkOutput("capt_br_ready", {7'd0, br_ready}, 8'd0);
      checkOutput("capt_fr_en", {7'd0, fr_en}, 8'd0);
      tick;
      @(negedge clk);
      checkOutput("commit_br_ready", {7'd0, br_ready}, {7'd0, FWD});
      tick;
      br_q.push_back(1'b1);
      @(negedge clk);
      checkOutput("idle_br_ready_z", {7'd0, br_ready}, 8'd1);
      checkOutput("idle_fr_en", {7'd0, fr_en}, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd3);
      br_q.push_back(1'b0);
      @(negedge clk);
      checkOutput("idle_br_ready_n", {7'd0, br_ready}, 8'd1);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd2);
      @(negedge clk);
      checkOutput("no_br_ready", {7'd0, br_ready}, 8'd0);
      checkOutput("no_br_taken", {7'd0, br_taken}, 8'd0);
      tick;

      // Both requesting from reset: ALU first, then RS granted in COMMIT
      rst = 1'b0;
      tick;
      rst = 1'b1;
      applyStimulus(1'b1, 4'b1010, 1'b1, 4'b0011, 1'b0, 2'd0);
      commit_q.push_back({4'b1010, 8'd1});
      @(negedge clk);
      checkOutput("rr0_alu_gnt", {7'd0, alu_gnt}, 8'd1);
      checkOutput("rr0_rs_gnt", {7'd0, rs_gnt}, 8'd0);
      tick;
      @(negedge clk);
      checkOutput("rr1_alu_gnt", {7'd0, alu_gnt}, 8'd0);
      checkOutput("rr1_rs_gnt", {7'd0, rs_gnt}, 8'd0);
      checkOutput("rr1_fr_en", {7'd0, fr_en}, 8'd0);
      tick;
      commit_q.push_back({4'b0011, 8'd2});
      @(negedge clk);
      checkOutput("rr2_alu_gnt", {7'd0, alu_gnt}, 8'd0);
      checkOutput("rr2_rs_gnt", {7'd0, rs_gnt}, 8'd1);
      checkOutput("rr2_fr_en", {7'd0, fr_en}, 8'd1);
      tick;
      @(negedge clk);
      checkOutput("rr3_rs_gnt", {7'd0, rs_gnt}, 8'd0);
      checkOutput("rr3_fr_en", {7'd0, fr_en}, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      tick;

      // Lone RS request, then a tie where ALU wins and RS follows
      applyStimulus(1'b0, 4'h0, 1'b1, 4'b1111, 1'b0, 2'd0);
      commit_q.push_back({4'b1111, 8'd3});
      @(negedge clk);
      checkOutput("rs_only_gnt", {7'd0, rs_gnt}, 8'd1);
      checkOutput("rs_only_alu_gnt", {7'd0, alu_gnt}, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      tick;
      tick;
      applyStimulus(1'b1, 4'b0001, 1'b1, 4'b1000, 1'b0, 2'd0);
      commit_q.push_back({4'b0001, 8'd4});
      @(negedge clk);
      checkOutput("tie_alu_gnt", {7'd0, alu_gnt}, 8'd1);
      tick;
      tick;
      commit_q.push_back({4'b1000, 8'd5});
      @(negedge clk);
      checkOutput("tie_rs_gnt", {7'd0, rs_gnt}, 8'd1);
      checkOutput("tie_alu_held", {7'd0, alu_gnt}, 8'd0);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      tick;
      tick;

      // Reset asserted mid-CAPT discards the pending update
      applyStimulus(1'b1, 4'b1100, 1'b0, 4'h0, 1'b0, 2'd0);
      @(negedge clk);
      checkOutput("abort_alu_gnt", {7'd0, alu_gnt}, 8'd1);
      tick;
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      rst = 1'b0;
      #1;
      checkOutput("abort_fr_en", {7'd0, fr_en}, 8'd0);
      checkOutput("abort_fr_flags", {4'd0, fr_flags}, 8'd0);
      checkOutput("abort_upd_cnt", upd_cnt, 8'd0);
      tick;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("post_abort_fr_en", {7'd0, fr_en}, 8'd0);
         checkOutput("post_abort_upd_cnt", upd_cnt, 8'd0);
         tick;
      end

      // 300 back-to-back ALU updates; count saturates at 255
      for (int k = 0; k < 300; k++) begin
         cnt_exp = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
         applyStimulus(1'b1, 4'(k), 1'b0, 4'h0, 1'b0, 2'd0);
         commit_q.push_back({4'(k), cnt_exp});
         @(negedge clk);
         checkOutput("burst_gnt", {7'd0, alu_gnt}, 8'd1);
         tick;
         @(negedge clk);
         checkOutput("burst_capt_gnt", {7'd0, alu_gnt}, 8'd0);
         tick;
      end
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
      tick;
      tick;
      @(negedge clk);
      checkOutput("sat_upd_cnt", upd_cnt, 8'd255);
      checkOutput("sat_fr_en", {7'd0, fr_en}, 8'd0);
      tick;

      checkOutput("commit_q_drained", 8'(commit_q.size()), 8'd0);
      checkOutput("br_q_drained", 8'(br_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
